// File: rtl/rv_pkg.sv
// Shared RV32I execute-stage types: ALU opcodes, forwarding/writeback selects,
// branch funct3 codes and the EX/MEM pipeline register layout.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  write_back;
    logic        load;
    logic        store;
    logic [31:0] alu_out;
    logic [31:0] op_b;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } exmem_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: shifts use the low five bits of src_b_i,
// add/sub wrap modulo 2^XLEN.
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  alu_op_t         alu_op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = src_b_i[4:0];

  always_comb begin
    // NOTE: default assignment first so every path drives result_o and no latch is inferred.
    result_o = '0;
    unique case (alu_op_i)
      ALU_ADD:   result_o = src_a_i + src_b_i;
      ALU_SUB:   result_o = src_a_i - src_b_i;
      ALU_SLL:   result_o = src_a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, src_a_i < src_b_i};
      ALU_XOR:   result_o = src_a_i ^ src_b_i;
      ALU_SRL:   result_o = src_a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(src_a_i) >>> shamt);
      ALU_OR:    result_o = src_a_i | src_b_i;
      ALU_AND:   result_o = src_a_i & src_b_i;
      ALU_PASSB: result_o = src_b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/exe_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register feeding the memory stage.
module exe_cycle
  import rv_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter logic [31:0] RST_PC4 = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_e,
  input  logic [1:0]      write_back_e,
  input  logic            load_e,
  input  logic            store_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic [3:0]      alu_op_e,
  input  logic            alu_src_a_e,
  input  logic            alu_src_b_e,
  input  logic [2:0]      funct3_e,
  input  logic [XLEN-1:0] op_a_e,
  input  logic [XLEN-1:0] op_b_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc4_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] rd_m_data,
  input  logic [XLEN-1:0] result_w,
  input  logic            stall_e,
  input  logic            flush_m,
  output logic            reg_write_m,
  output logic [1:0]      write_back_m,
  output logic            load_m,
  output logic            store_m,
  output logic [XLEN-1:0] alu_out_m,
  output logic [XLEN-1:0] op_b_m,
  output logic [XLEN-1:0] pc4_m,
  output logic [4:0]      rd_m,
  output logic            pc_sel_e,
  output logic [XLEN-1:0] target_e
);

  logic [XLEN-1:0] a, b_reg, src_a, src_b, alu_result, jalr_sum;
  logic            br_cond;
  exmem_t          exmem_d, exmem_q, exmem_new;

  always_comb begin
    a     = op_a_e;
    b_reg = op_b_e;
    unique case (fwd_sel_t'(fwd_a))
      FWD_MEM: a = rd_m_data;
      FWD_WB:  a = result_w;
      default: a = op_a_e;
    endcase
    unique case (fwd_sel_t'(fwd_b))
      FWD_MEM: b_reg = rd_m_data;
      FWD_WB:  b_reg = result_w;
      default: b_reg = op_b_e;
    endcase
  end

  assign src_a = alu_src_a_e ? pc_e  : a;
  assign src_b = alu_src_b_e ? imm_e : b_reg;

  alu #(.XLEN(XLEN)) u_alu (
    .src_a_i  (src_a),
    .src_b_i  (src_b),
    .alu_op_i (alu_op_t'(alu_op_e)),
    .result_o (alu_result)
  );

  // Branches compare the forwarded registers, never the immediate-muxed ALU inputs.
  always_comb begin
    br_cond = 1'b0;
    unique case (funct3_e)
      BR_BEQ:  br_cond = (a == b_reg);
      BR_BNE:  br_cond = (a != b_reg);
      BR_BLT:  br_cond = ($signed(a) <  $signed(b_reg));
      BR_BGE:  br_cond = ($signed(a) >= $signed(b_reg));
      BR_BLTU: br_cond = (a <  b_reg);
      BR_BGEU: br_cond = (a >= b_reg);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum = a + imm_e;
  assign pc_sel_e = jump_e | jalr_e | (branch_e & br_cond);
  assign target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_e);

  always_comb begin
    exmem_new.reg_write  = reg_write_e;
    exmem_new.write_back = write_back_e;
    exmem_new.load       = load_e;
    exmem_new.store      = store_e;
    exmem_new.alu_out    = alu_result;
    exmem_new.op_b       = b_reg;
    exmem_new.pc4        = pc4_e;
    exmem_new.rd         = rd_e;
  end

  // Flush outranks stall; a flushed slot still loads data but carries no side effects.
  always_comb begin
    exmem_d = exmem_q;
    if (flush_m) begin
      exmem_d            = exmem_new;
      exmem_d.reg_write  = 1'b0;
      exmem_d.write_back = 2'b00;
      exmem_d.load       = 1'b0;
      exmem_d.store      = 1'b0;
      exmem_d.rd         = 5'd0;
    end else if (!stall_e) begin
      exmem_d = exmem_new;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      exmem_q     <= '0;
      exmem_q.pc4 <= RST_PC4;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign reg_write_m  = exmem_q.reg_write;
  assign write_back_m = exmem_q.write_back;
  assign load_m       = exmem_q.load;
  assign store_m      = exmem_q.store;
  assign alu_out_m    = exmem_q.alu_out;
  assign op_b_m       = exmem_q.op_b;
  assign pc4_m        = exmem_q.pc4;
  assign rd_m         = exmem_q.rd;

endmodule

// File: tb/tb_exe_cycle.sv
// Scoreboard bench for exe_cycle: directed corner vectors plus randomized traffic
// checked against a behavioural model of the execute stage.
module tb_exe_cycle;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC4 = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reg_write_e, load_e, store_e, branch_e, jump_e, jalr_e;
  logic        alu_src_a_e, alu_src_b_e, stall_e, flush_m;
  logic [1:0]  write_back_e, fwd_a, fwd_b;
  logic [3:0]  alu_op_e;
  logic [2:0]  funct3_e;
  logic [31:0] op_a_e, op_b_e, imm_e, pc_e, pc4_e, rd_m_data, result_w;
  logic [4:0]  rd_e;
  logic        reg_write_m, load_m, store_m, pc_sel_e;
  logic [1:0]  write_back_m;
  logic [31:0] alu_out_m, op_b_m, pc4_m, target_e;
  logic [4:0]  rd_m;

  exe_cycle #(.XLEN(32), .RST_PC4(RST_PC4)) dut (
    .clk(clk), .rst(rst), .reg_write_e(reg_write_e), .write_back_e(write_back_e),
    .load_e(load_e), .store_e(store_e), .branch_e(branch_e), .jump_e(jump_e),
    .jalr_e(jalr_e), .alu_op_e(alu_op_e), .alu_src_a_e(alu_src_a_e),
    .alu_src_b_e(alu_src_b_e), .funct3_e(funct3_e), .op_a_e(op_a_e), .op_b_e(op_b_e),
    .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e), .rd_e(rd_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .rd_m_data(rd_m_data), .result_w(result_w), .stall_e(stall_e), .flush_m(flush_m),
    .reg_write_m(reg_write_m), .write_back_m(write_back_m), .load_m(load_m),
    .store_m(store_m), .alu_out_m(alu_out_m), .op_b_m(op_b_m), .pc4_m(pc4_m),
    .rd_m(rd_m), .pc_sel_e(pc_sel_e), .target_e(target_e)
  );

  typedef struct {
    logic        rst, reg_write, load, store, branch, jump, jalr, src_a, src_b, stall, flush;
    logic [1:0]  wb, fwd_a, fwd_b;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, imm, pc, pc4, rd_m_data, result_w;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic        reg_write, load, store;
    logic [1:0]  wb;
    logic [31:0] alu_out, op_b, pc4;
    logic [4:0]  rd;
  } reg_exp_t;

  typedef struct {
    logic        pc_sel;
    logic [31:0] target;
  } comb_exp_t;

  reg_exp_t  reg_q[$];
  comb_exp_t comb_q[$];
  reg_exp_t  model;
  int vectors = 0, miscompares = 0, n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    int sh = int'(y % 32);
    case (alu_op_t'(op))
      ALU_ADD:   return x + y;
      ALU_SUB:   return x + (~y + 32'd1);
      ALU_SLL:   return x * (32'd1 << sh);
      ALU_SLT:   return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return ({1'b0, x} < {1'b0, y}) ? 32'd1 : 32'd0;
      ALU_XOR:   return x ^ y;
      ALU_SRL:   return x / (32'd1 << sh);
      ALU_SRA:   return (x >> sh) | ((x[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      ALU_OR:    return x | y;
      ALU_AND:   return x & y;
      ALU_PASSB: return y;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] x,
                                     input logic [31:0] y);
    case (f3)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return int'(x) <  int'(y);
      3'b101:  return int'(x) >= int'(y);
      3'b110:  return longint'({32'd0, x}) <  longint'({32'd0, y});
      3'b111:  return longint'({32'd0, x}) >= longint'({32'd0, y});
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'b01) return mem;
    if (sel == 2'b10) return wb;
    return rf;
  endfunction

  // Drive one vector, push its expectations, then advance to just past the next edge.
  task automatic apply(input vec_t v);
    logic [31:0] a, b, sa, sb;
    comb_exp_t   c;
    rst = v.rst; reg_write_e = v.reg_write; write_back_e = v.wb; load_e = v.load;
    store_e = v.store; branch_e = v.branch; jump_e = v.jump; jalr_e = v.jalr;
    alu_op_e = v.alu_op; alu_src_a_e = v.src_a; alu_src_b_e = v.src_b; funct3_e = v.funct3;
    op_a_e = v.op_a; op_b_e = v.op_b; imm_e = v.imm; pc_e = v.pc; pc4_e = v.pc4; rd_e = v.rd;
    fwd_a = v.fwd_a; fwd_b = v.fwd_b; rd_m_data = v.rd_m_data; result_w = v.result_w;
    stall_e = v.stall; flush_m = v.flush;

    a  = pick_fwd(v.fwd_a, v.op_a, v.rd_m_data, v.result_w);
    b  = pick_fwd(v.fwd_b, v.op_b, v.rd_m_data, v.result_w);
    sa = v.src_a ? v.pc : a;
    sb = v.src_b ? v.imm : b;
    c.pc_sel = v.jump || v.jalr || (v.branch && ref_taken(v.funct3, a, b));
    c.target = v.jalr ? ((a + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    comb_q.push_back(c);

    if (v.rst) begin
      model = '{chk_data: 1'b1, reg_write: 1'b0, load: 1'b0, store: 1'b0, wb: 2'b00,
                alu_out: 32'd0, op_b: 32'd0, pc4: RST_PC4, rd: 5'd0};
    end else if (v.flush) begin
      model.reg_write = 1'b0; model.load = 1'b0; model.store = 1'b0;
      model.wb = 2'b00; model.rd = 5'd0; model.chk_data = 1'b0;
    end else if (!v.stall) begin
      model = '{chk_data: 1'b1, reg_write: v.reg_write, load: v.load, store: v.store,
                wb: v.wb, alu_out: ref_alu(v.alu_op, sa, sb), op_b: b, pc4: v.pc4, rd: v.rd};
    end
    reg_q.push_back(model);
    vectors++;
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.pc  = 32'h0000_2000;
    v.pc4 = 32'h0000_2004;
    return v;
  endfunction

  function automatic logic [31:0] rand32();
    logic [31:0] edge_vals [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic vec_t random_vec();
    vec_t v;
    v.rst = ($urandom_range(0, 39) == 0);
    v.reg_write = 1'($urandom); v.load = 1'($urandom); v.store = 1'($urandom);
    v.branch = 1'($urandom); v.jump = ($urandom_range(0, 5) == 0);
    v.jalr = ($urandom_range(0, 5) == 0);
    v.src_a = ($urandom_range(0, 4) == 0); v.src_b = 1'($urandom);
    v.stall = ($urandom_range(0, 5) == 0); v.flush = ($urandom_range(0, 7) == 0);
    v.wb = 2'($urandom_range(0, 2)); v.fwd_a = 2'($urandom); v.fwd_b = 2'($urandom);
    v.alu_op = 4'($urandom_range(0, 10)); v.funct3 = 3'($urandom);
    v.op_a = rand32(); v.op_b = ($urandom_range(0, 3) == 0) ? v.op_a : rand32();
    v.imm = rand32(); v.pc = $urandom & 32'hFFFF_FFFC; v.pc4 = v.pc + 32'd4;
    v.rd_m_data = rand32(); v.result_w = rand32(); v.rd = 5'($urandom);
    return v;
  endfunction

  // Monitor: combinational redirect mid-cycle, EX/MEM register just after the edge.
  initial begin
    comb_exp_t c;
    reg_exp_t  r;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check("pc_sel_e", {31'd0, pc_sel_e}, {31'd0, c.pc_sel});
        if (c.pc_sel) check("target_e", target_e, c.target);
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        check("reg_write_m", {31'd0, reg_write_m}, {31'd0, r.reg_write});
        check("load_m", {31'd0, load_m}, {31'd0, r.load});
        check("store_m", {31'd0, store_m}, {31'd0, r.store});
        check("write_back_m", {30'd0, write_back_m}, {30'd0, r.wb});
        check("rd_m", {27'd0, rd_m}, {27'd0, r.rd});
        if (r.chk_data) begin
          check("alu_out_m", alu_out_m, r.alu_out);
          check("op_b_m", op_b_m, r.op_b);
          check("pc4_m", pc4_m, r.pc4);
        end
      end
    end
  end

  initial begin
    vec_t v;
    @(posedge clk);
    #2;
    v = blank(); v.rst = 1'b1; v.reg_write = 1'b1; v.store = 1'b1; v.rd = 5'd9;
    apply(v);
    apply(v);

    v = blank(); v.alu_op = 4'(ALU_ADD); v.op_a = 32'd5; v.imm = 32'd7; v.src_b = 1'b1;
    v.reg_write = 1'b1; v.rd = 5'd3;
    apply(v);
    v = blank(); v.alu_op = 4'(ALU_SUB); v.fwd_a = 2'b01; v.rd_m_data = 32'h100;
    v.op_b = 32'd1; v.rd = 5'd4; v.reg_write = 1'b1;
    apply(v);
    v = blank(); v.store = 1'b1; v.fwd_b = 2'b10; v.result_w = 32'hDEAD_BEEF;
    v.op_b = 32'h1111_1111;
    apply(v);
    v = blank(); v.branch = 1'b1; v.funct3 = 3'b100; v.op_a = 32'hFFFF_FFFF;
    v.op_b = 32'd1; v.imm = 32'h40;
    apply(v);
    v.funct3 = 3'b110;
    apply(v);
    v = blank(); v.jalr = 1'b1; v.op_a = 32'h1003; v.imm = 32'd4; v.wb = 2'b10;
    v.pc4 = 32'h1234; v.reg_write = 1'b1; v.rd = 5'd1;
    apply(v);
    v = blank(); v.alu_op = 4'(ALU_SRA); v.op_a = 32'h8000_0000; v.imm = 32'h21;
    v.src_b = 1'b1;
    apply(v);
    v = blank(); v.alu_op = 4'(ALU_SLL); v.op_a = 32'h1234_5678; v.op_b = 32'd0;
    apply(v);
    v = blank(); v.alu_op = 4'(ALU_OR); v.op_a = 32'hA5A5_0000; v.op_b = 32'h5A5A;
    v.reg_write = 1'b1; v.load = 1'b1; v.wb = 2'b01; v.rd = 5'd7;
    apply(v);
    v.stall = 1'b1; v.op_a = 32'h0; v.rd = 5'd8; v.load = 1'b0;
    apply(v);
    apply(v);
    v.flush = 1'b1;
    apply(v);
    v = blank(); v.rd = 5'd0; v.reg_write = 1'b1; v.alu_op = 4'(ALU_PASSB);
    v.op_b = 32'hCAFE_F00D;
    apply(v);
    v = blank(); v.store = 1'b1; v.reg_write = 1'b1; v.rd = 5'd12; v.rst = 1'b1;
    apply(v);

    for (int i = 0; i < 600; i++) apply(random_vec());

    v = blank();
    apply(v);
    repeat (3) @(posedge clk);
    #3;
    if (reg_q.size() != 0 || comb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d reg and %0d comb expectations left, required 0",
               reg_q.size(), comb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
